pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter unit for the training datapath: successor to the plain PC register. It holds the current PC and updates it under chip-select/write-enable with selectable increment, relative branch, absolute jump, call and return. Call/return use an internal return-address stack (RAS) of configurable depth with overflow and underflow flags. Output gating follows the existing chip-select/output-enable scheme, so it drops into the memory-side datapath unchanged.

## Interface
- WORD_SIZE, 32, PC and data width in bits (≥8)
- RESET_VECTOR, 0, PC value after reset or op CLR
- INC_STEP, 4, increment added by INC and used as the CALL return offset
- RAS_DEPTH, 4, number of RAS entries (power of two, ≥2); stack pointer width is log2(RAS_DEPTH)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_cs  in  1  chip select; no update and no output when low
- i_we  in  1  write enable; update occurs only when i_cs && i_we
- i_oe  in  1  output enable for o_data_out
- i_op  in  3  operation select (see Operation)
- i_data_in  in  WORD_SIZE  branch offset or target address
- o_data_out  out  WORD_SIZE  PC when i_cs && i_oe, else 0 (combinational)
- o_pc  out  WORD_SIZE  raw registered PC, always driven
- o_ras_empty  out  1  RAS count == 0
- o_ras_full  out  1  RAS count == RAS_DEPTH
- o_ovf  out  1  sticky: a CALL was made while the RAS was full
- o_unf  out  1  sticky: a RET was made while the RAS was empty

## Operation
- Reset (i_rst low, asynchronous): PC=RESET_VECTOR, RAS count=0, pointer=0, o_ovf=o_unf=0. Stack contents are don't-care.
- Ops take effect on the rising edge when i_cs && i_we. Otherwise all state holds.
- 000 HOLD: no change.
- 001 INC: PC ← PC + INC_STEP.
- 010 REL: PC ← PC + i_data_in, with i_data_in taken as two's complement.
- 011 ABS: PC ← i_data_in.
- 100 CALL: push PC + INC_STEP, then PC ← i_data_in.
- 101 RET: pop the top entry into PC.
- 110 CLR: PC=RESET_VECTOR, RAS emptied, o_ovf and o_unf cleared.
- 111 reserved: behaves as HOLD.
- Arithmetic: all sums are modulo 2^WORD_SIZE. Wrap-around is silent and raises no flag.
- RAS is circular. Push writes at the pointer, then the pointer increments. Pop decrements the pointer, then reads.
- Count rules:
  - CALL with count < RAS_DEPTH: count increments.
  - CALL when full: the oldest entry is overwritten, count stays at RAS_DEPTH, o_ovf is set, and the jump still occurs.
  - RET with count > 0: count decrements.
  - RET when empty: PC holds, pointer and count are unchanged, o_unf is set.
- o_ovf and o_unf stay set until reset or CLR.
- o_data_out and o_pc are independent of i_we.

## Timing
- All state updates occur on the rising edge of i_clk. Latency is one cycle: the new PC appears on o_pc and o_data_out after the updating edge.
- o_data_out gating is combinational on i_cs and i_oe, with zero latency.
- Flags, o_ras_empty and o_ras_full reflect post-edge state in the same cycle as the PC.
- Flags set by an op are visible after that op's edge.
- Back-to-back ops are allowed every cycle, including CALL followed immediately by RET. That RET returns the just-pushed value.
- Reset asserted mid-sequence: outputs take reset values immediately, without waiting for a clock edge. The first op after release acts on reset state.
- i_data_in is sampled only at the updating edge.

## Test plan
- Reset then INC ×3, RESET_VECTOR=0, INC_STEP=4, cs=we=1 -> o_pc 0,4,8,12. With oe=0, o_data_out=0. With oe=1, o_data_out=12.
- PC=0x10, REL i_data_in=0xFFFFFFF8 -> PC=0x08. PC=0xFFFFFFFC, INC -> PC=0x00000000, no flags.
- cs=1, we=0, op=ABS, data=0x100 -> PC unchanged. Next cycle we=1 -> PC=0x100.
- RAS_DEPTH=4, PC=0: CALL 0x100, 0x200, 0x300, 0x400 -> full=1, ovf=0. CALL 0x500 -> ovf=1, PC=0x500. RET ×4 -> PC 0x404, 0x304, 0x204, 0x104, then empty=1.
- Empty RAS, PC=0x40, RET -> PC=0x40, unf=1. CLR -> PC=RESET_VECTOR, unf=0, ovf=0.
- CALL 0x80 from PC=0x20, then i_rst low between edges -> o_pc=RESET_VECTOR and empty=1 immediately. After release, RET -> unf=1.

Source files
------------

// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit with a circular return-address stack (RAS).
// The PC is updated on the rising edge whenever i_cs && i_we. The operation
// is selected by i_op: hold, increment, relative branch, absolute jump, call,
// return, clear, or reserved (acts as hold).
//
// A CALL pushes PC + INC_STEP and jumps to i_data_in. A RET pops the top entry
// into the PC. When the RAS is full, a CALL overwrites the oldest entry and
// sets the sticky o_ovf flag. A RET on an empty RAS leaves the PC as it is and
// sets the sticky o_unf flag.
//
// Handshake: this block has no valid/ready handshake. An operation is taken
// on every rising edge where i_cs && i_we, so the caller may issue one op per
// cycle with no back-pressure.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active low
//   i_cs         chip select; gates updates and o_data_out
//   i_we         write enable; an update happens only when i_cs && i_we
//   i_oe         output enable for o_data_out
//   i_op[2:0]    operation select
//   i_data_in    branch offset (two's complement) or target address
//   o_data_out   PC when i_cs && i_oe, else 0 (combinational)
//   o_pc         registered PC, always driven
//   o_ras_empty  RAS holds no entries
//   o_ras_full   RAS holds RAS_DEPTH entries
//   o_ovf        sticky: CALL made while the RAS was full
//   o_unf        sticky: RET made while the RAS was empty
// -----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
    parameter logic [WORD_SIZE-1:0] INC_STEP     = WORD_SIZE'(4),
    parameter int                   RAS_DEPTH    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cs,
    input  logic                 i_we,
    input  logic                 i_oe,
    input  logic [2:0]           i_op,
    input  logic [WORD_SIZE-1:0] i_data_in,
    output logic [WORD_SIZE-1:0] o_data_out,
    output logic [WORD_SIZE-1:0] o_pc,
    output logic                 o_ras_empty,
    output logic                 o_ras_full,
    output logic                 o_ovf,
    output logic                 o_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    // One extra bit so the count can hold the value RAS_DEPTH itself.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_INC  = 3'b001,
        OP_REL  = 3'b010,
        OP_ABS  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101,
        OP_CLR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    // Registered state
    logic [WORD_SIZE-1:0] r_pc;
    logic [PTR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic                 r_unf;
    logic [WORD_SIZE-1:0] r_ras [RAS_DEPTH];

    // Next-state signals
    op_e                  w_op;
    logic                 w_update;
    logic [WORD_SIZE-1:0] w_pc_nxt;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_ovf_nxt;
    logic                 w_unf_nxt;
    logic                 w_push;
    logic [WORD_SIZE-1:0] w_push_data;
    logic [PTR_W-1:0]     w_ptr_dec;

    assign w_op        = op_e'(i_op);
    assign w_update    = i_cs && i_we;
    assign w_push_data = r_pc + INC_STEP;
    assign w_ptr_dec   = r_ptr - PTR_W'(1);

    always_comb begin
        w_pc_nxt  = r_pc;
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        w_push    = 1'b0;
        if (w_update) begin
            case (w_op)
                OP_INC:  w_pc_nxt = r_pc + INC_STEP;
                // Unsigned add gives the two's-complement result modulo 2^W.
                OP_REL:  w_pc_nxt = r_pc + i_data_in;
                OP_ABS:  w_pc_nxt = i_data_in;
                OP_CALL: begin
                    // When the stack is full the pointer sits on the oldest
                    // entry, so writing at the pointer overwrites that entry.
                    w_push    = 1'b1;
                    w_ptr_nxt = r_ptr + PTR_W'(1);
                    w_pc_nxt  = i_data_in;
                    if (r_cnt == DEPTH_C) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (r_cnt == '0) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = w_ptr_dec;
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                        w_pc_nxt  = r_ras[w_ptr_dec];
                    end
                end
                OP_CLR: begin
                    w_pc_nxt  = RESET_VECTOR;
                    w_ptr_nxt = '0;
                    w_cnt_nxt = '0;
                    w_ovf_nxt = 1'b0;
                    w_unf_nxt = 1'b0;
                end
                default: ; // OP_HOLD and OP_RSVD keep all state
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pc  <= RESET_VECTOR;
            r_ptr <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    // Stack storage is not reset: an entry is only read after it has been
    // pushed, because the count guards every pop.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_push_data;
        end
    end

    assign o_pc        = r_pc;
    assign o_data_out  = (i_cs && i_oe) ? r_pc : '0;
    assign o_ras_empty = (r_cnt == '0);
    assign o_ras_full  = (r_cnt == DEPTH_C);
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam int          W     = 32;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] STEP  = 32'd4;
  localparam int          DEPTH = 4;

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, REL = 3'b010, ABS = 3'b011,
                         CALL = 3'b100, RET = 3'b101, CLR = 3'b110, RSVD = 3'b111;

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_cs = 1'b0, i_we = 1'b0, i_oe = 1'b0;
  logic [2:0]    i_op = 3'b000;
  logic [W-1:0]  i_data_in = '0;
  logic [W-1:0]  o_data_out, o_pc;
  logic          o_ras_empty, o_ras_full, o_ovf, o_unf;

  always #5 i_clk = ~i_clk;

  pc_stack_unit #(
    .WORD_SIZE(W), .RESET_VECTOR(RV), .INC_STEP(STEP), .RAS_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs), .i_we(i_we), .i_oe(i_oe),
    .i_op(i_op), .i_data_in(i_data_in), .o_data_out(o_data_out), .o_pc(o_pc),
    .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  // ---------------- behavioural model ----------------
  // The stack is a plain queue: newest at the back, oldest dropped from the front.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_ovf, m_unf;

  function automatic void model_reset();
    m_pc = RV;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [W-1:0] d);
    case (op)
      INC: m_pc = m_pc + STEP;
      REL: m_pc = m_pc + d;
      ABS: m_pc = d;
      CALL: begin
        if (m_stack.size() == DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1'b1;
        end
        m_stack.push_back(m_pc + STEP);
        m_pc = d;
      end
      RET: begin
        if (m_stack.size() == 0) m_unf = 1'b1;
        else m_pc = m_stack.pop_back();
      end
      CLR: model_reset();
      default: ;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("cyc_pc", o_pc, m_pc);
      chk("cyc_data_out", o_data_out, (i_cs && i_oe) ? m_pc : '0);
      chk("cyc_empty", W'(o_ras_empty), W'(m_stack.size() == 0));
      chk("cyc_full", W'(o_ras_full), W'(m_stack.size() == DEPTH));
      chk("cyc_ovf", W'(o_ovf), W'(m_ovf));
      chk("cyc_unf", W'(o_unf), W'(m_unf));
    end
  end

  // ---------------- driver ----------------
  // Inputs are applied just after a rising edge; on return we sit 2 time units
  // after the updating edge, with outputs settled.
  task automatic step(input logic cs, input logic we, input logic oe,
                      input logic [2:0] op, input logic [W-1:0] d);
    i_cs = cs; i_we = we; i_oe = oe; i_op = op; i_data_in = d;
    @(posedge i_clk);
    if (i_rst && cs && we) model_apply(op, d);
    #2;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] d);
    step(1'b1, 1'b1, 1'b1, op, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    chk("reset_pc", o_pc, 32'h0);
    chk("reset_empty", W'(o_ras_empty), 32'd1);
    chk_en = 1'b1;

    // Increment sequence with output disabled, then enabled.
    step(1'b1, 1'b1, 1'b0, INC, '0); chk("inc1_pc", o_pc, 32'd4);
    step(1'b1, 1'b1, 1'b0, INC, '0); chk("inc2_pc", o_pc, 32'd8);
    step(1'b1, 1'b1, 1'b0, INC, '0); chk("inc3_pc", o_pc, 32'd12);
    chk("oe0_data_out", o_data_out, 32'd0);
    i_oe = 1'b1; i_we = 1'b0; #1;
    chk("oe1_data_out", o_data_out, 32'd12);
    i_cs = 1'b0; #1;
    chk("cs0_data_out", o_data_out, 32'd0);

    // Relative branch backwards and silent wrap-around.
    do_op(ABS, 32'h10);
    do_op(REL, 32'hFFFF_FFF8); chk("rel_back_pc", o_pc, 32'h08);
    do_op(ABS, 32'hFFFF_FFFC);
    do_op(INC, '0);            chk("inc_wrap_pc", o_pc, 32'h0);
    chk("wrap_no_ovf", W'(o_ovf), 32'd0);

    // Write enable and chip select gate updates.
    step(1'b1, 1'b0, 1'b1, ABS, 32'h100); chk("we0_hold_pc", o_pc, 32'h0);
    step(1'b1, 1'b1, 1'b1, ABS, 32'h100); chk("we1_abs_pc", o_pc, 32'h100);
    step(1'b0, 1'b1, 1'b1, INC, '0);      chk("cs0_hold_pc", o_pc, 32'h100);
    do_op(HOLD, 32'h55);                  chk("hold_pc", o_pc, 32'h100);
    do_op(RSVD, 32'h55);                  chk("rsvd_pc", o_pc, 32'h100);

    // Fill the stack, overflow it, then drain it.
    do_op(ABS, 32'h0);
    do_op(CALL, 32'h100);
    do_op(CALL, 32'h200);
    do_op(CALL, 32'h300);
    do_op(CALL, 32'h400);
    chk("fill_full", W'(o_ras_full), 32'd1);
    chk("fill_no_ovf", W'(o_ovf), 32'd0);
    do_op(CALL, 32'h500);
    chk("ovf_set", W'(o_ovf), 32'd1);
    chk("ovf_pc", o_pc, 32'h500);
    do_op(RET, '0); chk("ret1_pc", o_pc, 32'h404);
    do_op(RET, '0); chk("ret2_pc", o_pc, 32'h304);
    do_op(RET, '0); chk("ret3_pc", o_pc, 32'h204);
    do_op(RET, '0); chk("ret4_pc", o_pc, 32'h104);
    chk("drain_empty", W'(o_ras_empty), 32'd1);

    // Underflow then clear.
    do_op(ABS, 32'h40);
    do_op(RET, '0);
    chk("unf_pc", o_pc, 32'h40);
    chk("unf_set", W'(o_unf), 32'd1);
    do_op(CLR, '0);
    chk("clr_pc", o_pc, RV);
    chk("clr_unf", W'(o_unf), 32'd0);
    chk("clr_ovf", W'(o_ovf), 32'd0);

    // CALL immediately followed by RET returns the just-pushed address.
    do_op(ABS, 32'h20);
    do_op(CALL, 32'h80); chk("b2b_call_pc", o_pc, 32'h80);
    do_op(RET, '0);      chk("b2b_ret_pc", o_pc, 32'h24);

    // Asynchronous reset between edges.
    do_op(CALL, 32'h80);
    #1;
    i_rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", o_pc, RV);
    chk("async_rst_empty", W'(o_ras_empty), 32'd1);
    #3;
    i_rst = 1'b1;
    do_op(RET, '0);
    chk("post_rst_unf", W'(o_unf), 32'd1);
    chk("post_rst_pc", o_pc, RV);

    // Wrap across the circular pointer a second time with mixed ops.
    do_op(CLR, '0);
    for (int i = 0; i < 6; i++) do_op(CALL, 32'h1000 * (i + 1));
    do_op(RET, '0); chk("wrap_ret_pc", o_pc, 32'h5004);
    do_op(REL, 32'h10);
    do_op(RET, '0);
    do_op(RET, '0);
    do_op(RET, '0); chk("wrap_last_pc", o_pc, 32'h2004);
    do_op(RET, '0); chk("wrap_unf", W'(o_unf), 32'd1);

    @(posedge i_clk);
    #2;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
